// File: rtl/fp_mult_arbiter_pkg.sv
// Shared float32 constants, IP latencies and the requester tag type used by
// the multiplier and adder sharing logic.
package fp_mult_arbiter_pkg;
    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
    localparam int          MULT_LAT = 6;
    localparam int          ADD_LAT  = 11;

    typedef struct packed {
        logic       v;
        logic [2:0] id;
    } req_tag_t;
endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester, multiplier-IP and result signals of the shared float32 multiplier.
interface fp_mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [31:0]        req_a [NUM_REQ];
    logic [31:0]        req_b [NUM_REQ];
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [31:0]        mult_a_out;
    logic [31:0]        mult_b_out;
    logic               mult_v_out;
    logic [31:0]        mult_result;
    logic               mult_result_valid;
    logic [31:0]        res_data;
    logic [NUM_REQ-1:0] res_valid;
    logic               tag_err;

    modport master (
        output req_a, req_b, req_valid, mult_result, mult_result_valid,
        input  req_ready, mult_a_out, mult_b_out, mult_v_out, res_data, res_valid, tag_err
    );

    modport slave (
        input  req_a, req_b, req_valid, mult_result, mult_result_valid,
        output req_ready, mult_a_out, mult_b_out, mult_v_out, res_data, res_valid, tag_err
    );
endinterface

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request above the last winner.
// The pointer lives here so the same block can front the adder IP as well.
module rr_arbiter
    import fp_mult_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] grant_idx_in,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_j;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ptr <= IW'(N - 1);
        end else if (advance) begin
            r_ptr <= grant_idx_in;
        end
    end

    // Walk the search order backwards so the nearest request above r_ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_j       = '0;
        if (!rst_in) begin
            for (int k = N; k >= 1; k--) begin
                w_j = IW'((int'(r_ptr) + k) % N);
                if (req[w_j]) begin
                    grant      = '0;
                    grant[w_j] = 1'b1;
                    grant_idx  = w_j;
                end
            end
        end
    end
endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined float32 multiplier between NUM_REQ requesters; a tag pipe
// matched to the multiplier latency steers each result back to its issuer.
module fp_mult_arbiter
    import fp_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    fp_mult_arbiter_if.slave    bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = $clog2(MULT_LAT + 2);

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_grant_idx;
    logic               w_hs;
    req_tag_t           w_tail;

    logic [31:0]        r_mult_a;
    logic [31:0]        r_mult_b;
    logic               r_mult_v;
    req_tag_t           r_tag_p [MULT_LAT+1];
    logic [31:0]        r_res_data;
    logic [NUM_REQ-1:0] r_res_valid;
    logic [DW-1:0]      r_drain;
    logic               r_tag_err;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req          (bus.req_valid),
        .advance      (w_hs),
        .grant_idx_in (w_grant_idx),
        .grant        (w_grant),
        .grant_idx    (w_grant_idx)
    );

    // A grant is only ever given to a valid requester, so any grant is a handshake.
    assign w_hs   = |w_grant;
    assign w_tail = r_tag_p[MULT_LAT];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mult_a    <= FP_ZERO;
            r_mult_b    <= FP_ZERO;
            r_mult_v    <= 1'b0;
            for (int k = 0; k <= MULT_LAT; k++) r_tag_p[k] <= '0;
            r_res_data  <= FP_ZERO;
            r_res_valid <= '0;
            r_drain     <= DW'(MULT_LAT + 1);
            r_tag_err   <= 1'b0;
        end else begin
            // Issue stage: operands held when idle, tag pipe always shifts.
            r_mult_v <= w_hs;
            if (w_hs) begin
                r_mult_a <= bus.req_a[w_grant_idx];
                r_mult_b <= bus.req_b[w_grant_idx];
            end
            r_tag_p[0] <= '{v: w_hs, id: 3'(w_grant_idx)};
            for (int k = 1; k <= MULT_LAT; k++) r_tag_p[k] <= r_tag_p[k-1];

            // Result stage: tail tag lines up with the multiplier output valid.
            if (w_tail.v && bus.mult_result_valid) begin
                r_res_data  <= bus.mult_result;
                r_res_valid <= NUM_REQ'(1) << w_tail.id;
            end else begin
                r_res_valid <= '0;
            end

            // Pre-reset multiplier results drain out while the counter is non-zero.
            if (r_drain != '0) begin
                r_drain <= r_drain - DW'(1);
            end else if (w_tail.v != bus.mult_result_valid) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.mult_a_out = r_mult_a;
    assign bus.mult_b_out = r_mult_b;
    assign bus.mult_v_out = r_mult_v;
    assign bus.res_data   = r_res_data;
    assign bus.res_valid  = r_res_valid;
    assign bus.tag_err    = r_tag_err;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: behavioural float32 multiplier with fault injection,
// a result scoreboard, table-driven single requests and arbitration/reset sequences.
module tb_fp_mult_arbiter;
    import fp_mult_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int LAT     = MULT_LAT;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_pass = 0;
    int          n_checks = 0;
    sb_t         sb_q[$];
    int          m_ptr = NUM_REQ - 1;
    int          res_cnt [NUM_REQ];
    int          glog[$];
    logic [32:0] mdl_p [LAT];
    int          mdl_cnt = 0;
    int          drop_idx = -1;

    fp_mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    fp_mult_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LAT(LAT)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        d = $realtobits(f2r(a) * f2r(b));
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Behavioural multiplier IP; the pulse numbered drop_idx loses its valid.
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) mdl_p[k] <= mdl_p[k-1];
        mdl_p[0] <= {(bus.mult_v_out === 1'b1) && (mdl_cnt != drop_idx),
                     fmul(bus.mult_a_out, bus.mult_b_out)};
        if (bus.mult_v_out === 1'b1) mdl_cnt <= mdl_cnt + 1;
    end
    assign bus.mult_result       = mdl_p[LAT-1][31:0];
    assign bus.mult_result_valid = mdl_p[LAT-1][32];

    // Grant model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : mon
        int  g;
        sb_t e;
        if (rst) begin
            check("ready_in_reset", 32'(bus.req_ready), 32'd0);
            sb_q.delete();
            m_ptr = NUM_REQ - 1;
        end else begin
            g = model_pick(bus.req_valid, m_ptr);
            check("grant", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                sb_q.push_back('{id: g, data: fmul(bus.req_a[g], bus.req_b[g])});
                m_ptr = g;
            end
            if (bus.res_valid != '0) begin
                for (int i = 0; i < NUM_REQ; i++) if (bus.res_valid[i]) res_cnt[i]++;
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.res_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_owner", 32'(bus.res_valid), 32'd1 << e.id);
                    check("sb_data", bus.res_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        av = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        bv = '{32'h3F00_0000, 32'hC000_0000, 32'h3FC0_0000, 32'h3E80_0000};
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i] = av[i];
            bus.req_b[i] = bv[i];
        end
    endtask

    // Drive valid for up to `cycles` edges, logging grants; optionally drop once granted.
    task automatic run_req(input logic [NUM_REQ-1:0] mask, input int cycles, input bit until_granted);
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] g;
        v = mask;
        glog.delete();
        for (int c = 0; c < cycles && v != '0; c++) begin
            bus.req_valid = v;
            @(negedge clk);
            g = bus.req_ready;
            for (int i = 0; i < NUM_REQ; i++) if (g[i]) glog.push_back(i);
            tick();
            if (until_granted) v = v & ~g;
        end
        bus.req_valid = '0;
    endtask

    task automatic drain_check(input string name);
        repeat (12) tick();
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [5];
        int   snap [NUM_REQ];
        int   tot;
        int   w;

        vt[0] = '{1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
        vt[1] = '{0, 32'h3F80_0000, 32'hC0A0_0000, 32'hC0A0_0000};
        vt[2] = '{2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
        vt[3] = '{3, 32'h0000_0000, 32'h42F6_0000, 32'h0000_0000};
        vt[4] = '{2, 32'hBF00_0000, 32'hC120_0000, 32'h40A0_0000};

        set_ops();
        bus.req_valid = 4'b1111;
        repeat (8) tick();
        bus.req_valid = '0;
        tick();
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mult_v", 32'(bus.mult_v_out), 32'd0);
        check("rst_mult_a", bus.mult_a_out, 32'd0);
        check("rst_mult_b", bus.mult_b_out, 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_tag_err", 32'(bus.tag_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four valid, each held until granted.
        run_req(4'b1111, 8, 1'b1);
        check("all4_ngrant", 32'(glog.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < glog.size()) check($sformatf("all4_grant%0d", k), 32'(glog[k]), 32'(k));
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("all4_res%0d", k), 32'(bus.res_valid), 32'd1 << k);
        end
        drain_check("all4_drained");

        // Requesters 0 and 2 continuously valid.
        snap = res_cnt;
        run_req(4'b0101, 10, 1'b0);
        check("alt_ngrant", 32'(glog.size()), 32'd10);
        for (int k = 0; k < 10; k++)
            if (k < glog.size()) check($sformatf("alt_grant%0d", k), 32'(glog[k]), (k % 2 == 0) ? 32'd0 : 32'd2);
        drain_check("alt_drained");
        check("alt_cnt0", 32'(res_cnt[0] - snap[0]), 32'd5);
        check("alt_cnt1", 32'(res_cnt[1] - snap[1]), 32'd0);
        check("alt_cnt2", 32'(res_cnt[2] - snap[2]), 32'd5);
        check("alt_cnt3", 32'(res_cnt[3] - snap[3]), 32'd0);

        // Lone requester 3: back-to-back issue and results.
        run_req(4'b1000, 8, 1'b0);
        check("lone_ngrant", 32'(glog.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < glog.size()) check($sformatf("lone_grant%0d", k), 32'(glog[k]), 32'd3);
        w = 0;
        @(negedge clk);
        while (bus.res_valid == '0 && w < 12) begin
            @(negedge clk);
            w++;
        end
        check("lone_latency", 32'(w), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("lone_res%0d", k), 32'(bus.res_valid), 32'b1000);
            @(negedge clk);
        end
        check("lone_after", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        drain_check("lone_drained");

        // Table-driven single requests with exact latency.
        for (int k = 0; k < 5; k++) begin
            bus.req_a[vt[k].id] = vt[k].a;
            bus.req_b[vt[k].id] = vt[k].b;
            bus.req_valid = 4'(1 << vt[k].id);
            tick();
            bus.req_valid = '0;
            @(negedge clk);
            check($sformatf("vec%0d_mult_v", k), 32'(bus.mult_v_out), 32'd1);
            check($sformatf("vec%0d_mult_a", k), bus.mult_a_out, vt[k].a);
            check($sformatf("vec%0d_mult_b", k), bus.mult_b_out, vt[k].b);
            @(negedge clk);
            check($sformatf("vec%0d_mult_v_pulse", k), 32'(bus.mult_v_out), 32'd0);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_early", k), 32'(bus.res_valid), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_owner", k), 32'(bus.res_valid), 32'd1 << vt[k].id);
            check($sformatf("vec%0d_data", k), bus.res_data, vt[k].exp);
            @(posedge clk);
            #1;
        end
        drain_check("vec_drained");

        // Reset three cycles after four issues.
        set_ops();
        snap = res_cnt;
        bus.req_valid = 4'b0001;
        repeat (3) tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (16) tick();
        tot = 0;
        for (int i = 0; i < NUM_REQ; i++) tot += res_cnt[i] - snap[i];
        check("rst_no_results", 32'(tot), 32'd0);
        check("rst_tag_err_low", 32'(bus.tag_err), 32'd0);
        bus.req_valid = 4'b0110;
        @(negedge clk);
        check("rst_next_grant", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        drain_check("rst_drained");

        // Dropped multiplier valid sets the sticky tag error.
        drop_idx = mdl_cnt;
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        repeat (6) @(negedge clk);
        check("fault_before", 32'(bus.tag_err), 32'd0);
        @(negedge clk);
        check("fault_set", 32'(bus.tag_err), 32'd1);
        repeat (5) @(negedge clk);
        check("fault_sticky", 32'(bus.tag_err), 32'd1);
        check("fault_no_result", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("fault_cleared", 32'(bus.tag_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
